// File: rtl/acq_tx_pkg.sv
// Shared types and constants for the acquisition-stream UDP TX packetizer.
package acq_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        FETCH,
        BYTES,
        CKSUM,
        STATUS
    } state_t;

    localparam int WORD_BITS   = 108;
    localparam int EXT_BITS    = 112;
    localparam int WORD_BYTES  = 14;
    localparam int HDR_BYTES   = 2;
    localparam int CKSUM_BYTES = 2;

    function automatic logic [95:0] pack_status(input logic [47:0] mac,
                                                input logic [31:0] ip,
                                                input logic [15:0] len);
        return {mac, ip, len};
    endfunction

endpackage

// File: rtl/acq_word_serializer.sv
// Turns one 108-bit acquisition word into 14 bytes, MSB first, advancing
// only on cycles where the downstream data FIFO accepts a byte.
module acq_word_serializer
    import acq_tx_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [WORD_BITS-1:0] load_word,
    input  logic                 advance,
    input  logic                 full,
    output logic [7:0]           data_byte,
    output logic                 write,
    output logic                 last
);

    logic [EXT_BITS-1:0] shreg;
    logic [3:0]          byte_idx;

    assign write     = advance && !full;
    assign last      = write && (byte_idx == 4'(WORD_BYTES - 1));
    assign data_byte = shreg[EXT_BITS-1 -: 8];

    // Word is zero-extended to 112 bits so the top nibble of the first byte is 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            byte_idx <= '0;
        end else if (load) begin
            shreg    <= {{(EXT_BITS - WORD_BITS){1'b0}}, load_word};
            byte_idx <= '0;
        end else if (write) begin
            shreg    <= {shreg[EXT_BITS-9:0], 8'h00};
            byte_idx <= last ? 4'd0 : byte_idx + 4'd1;
        end
    end

endmodule

// File: rtl/udp_acq_tx_packer.sv
// Packs acquisition words into sequence-numbered UDP payloads plus one status word per packet.
// Optional 16-bit payload checksum trailer enabled by defining ACQ_TX_CHECKSUM_EN.
module udp_acq_tx_packer
    import acq_tx_pkg::*;
#(
    parameter int WORDS_PER_PKT  = 64,
    parameter int TIMEOUT_CYCLES = 12500
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [47:0]          destination_mac,
    input  logic [31:0]          destination_ip,
    input  logic [WORD_BITS-1:0] acq_rddata_fifo_108,
    input  logic                 acq_rdempty_fifo_108,
    output logic                 acq_rdreq_fifo_108,
    output logic [7:0]           tx_fifo_data,
    output logic                 tx_fifo_data_write,
    input  logic                 tx_fifo_data_full,
    output logic [95:0]          tx_fifo_status,
    output logic                 tx_fifo_status_write,
    input  logic                 tx_fifo_status_full,
    output logic                 busy,
    output logic [31:0]          packet_count
);

`ifdef ACQ_TX_CHECKSUM_EN
    localparam bit CKSUM_EN = 1'b1;
`else
    localparam bit CKSUM_EN = 1'b0;
`endif

    localparam int     TRAILER_BYTES = CKSUM_EN ? CKSUM_BYTES : 0;
    localparam state_t TAIL_STATE    = CKSUM_EN ? CKSUM : STATUS;
    localparam int     CW            = $clog2(WORDS_PER_PKT + 1);
    localparam int     TW            = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t          state, next_state;
    logic [47:0]     mac_q;
    logic [31:0]     ip_q;
    logic [15:0]     seq;
    logic [CW-1:0]   word_cnt;
    logic [CW-1:0]   next_cnt;
    logic [TW-1:0]   idle_timer;
    logic            hdr_idx;
    logic [15:0]     payload_len;
    logic            ser_load;
    logic            ser_advance;
    logic [7:0]      ser_byte;
    logic            ser_write;
    logic            ser_last;
    logic            flush_now;

`ifdef ACQ_TX_CHECKSUM_EN
    logic [15:0]     cksum;
    logic            cksum_idx;
`endif

    assign next_cnt    = word_cnt + CW'(1);
    assign payload_len = 16'(HDR_BYTES + TRAILER_BYTES + WORD_BYTES * int'(word_cnt));
    assign flush_now   = (word_cnt != '0) && ((idle_timer == TIMER_LAST) || !enable);
    assign busy        = (state != IDLE);

    acq_word_serializer u_serializer (
        .clk       (clk),
        .reset     (reset),
        .load      (ser_load),
        .load_word (acq_rddata_fifo_108),
        .advance   (ser_advance),
        .full      (tx_fifo_data_full),
        .data_byte (ser_byte),
        .write     (ser_write),
        .last      (ser_last)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Strobes are masked while reset is high so an abandoned packet never leaks a write or pop.
    always_comb begin
        next_state           = state;
        acq_rdreq_fifo_108   = 1'b0;
        tx_fifo_data         = 8'h00;
        tx_fifo_data_write   = 1'b0;
        tx_fifo_status       = '0;
        tx_fifo_status_write = 1'b0;
        ser_load             = 1'b0;
        ser_advance          = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (enable && !acq_rdempty_fifo_108) next_state = HDR;
                end
                HDR: begin
                    tx_fifo_data       = hdr_idx ? seq[7:0] : seq[15:8];
                    tx_fifo_data_write = !tx_fifo_data_full;
                    if (!tx_fifo_data_full && hdr_idx) next_state = FETCH;
                end
                FETCH: begin
                    if (!acq_rdempty_fifo_108) begin
                        acq_rdreq_fifo_108 = 1'b1;
                        ser_load           = 1'b1;
                        next_state         = BYTES;
                    end else if (flush_now) begin
                        next_state = TAIL_STATE;
                    end
                end
                BYTES: begin
                    ser_advance        = 1'b1;
                    tx_fifo_data       = ser_byte;
                    tx_fifo_data_write = ser_write;
                    if (ser_last)
                        next_state = (next_cnt == CW'(WORDS_PER_PKT)) ? TAIL_STATE : FETCH;
                end
`ifdef ACQ_TX_CHECKSUM_EN
                CKSUM: begin
                    tx_fifo_data       = cksum_idx ? cksum[7:0] : cksum[15:8];
                    tx_fifo_data_write = !tx_fifo_data_full;
                    if (!tx_fifo_data_full && cksum_idx) next_state = STATUS;
                end
`endif
                STATUS: begin
                    tx_fifo_status       = pack_status(mac_q, ip_q, payload_len);
                    tx_fifo_status_write = !tx_fifo_status_full;
                    if (!tx_fifo_status_full) next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Packet context is captured at packet start so mid-packet MAC/IP changes cannot split a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            mac_q        <= '0;
            ip_q         <= '0;
            seq          <= '0;
            word_cnt     <= '0;
            idle_timer   <= '0;
            hdr_idx      <= 1'b0;
            packet_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && !acq_rdempty_fifo_108) begin
                        mac_q      <= destination_mac;
                        ip_q       <= destination_ip;
                        word_cnt   <= '0;
                        idle_timer <= '0;
                        hdr_idx    <= 1'b0;
                    end
                end
                HDR: begin
                    if (tx_fifo_data_write) hdr_idx <= 1'b1;
                end
                FETCH: begin
                    if (!acq_rdempty_fifo_108)    idle_timer <= '0;
                    else if (idle_timer != TIMER_LAST) idle_timer <= idle_timer + TW'(1);
                end
                BYTES: begin
                    if (ser_last) word_cnt <= next_cnt;
                end
                STATUS: begin
                    if (tx_fifo_status_write) begin
                        seq          <= seq + 16'd1;
                        packet_count <= packet_count + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ACQ_TX_CHECKSUM_EN
    // Sum covers header and data bytes only; the trailer bytes themselves are excluded.
    always_ff @(posedge clk) begin
        if (reset) begin
            cksum     <= '0;
            cksum_idx <= 1'b0;
        end else if (state == IDLE) begin
            cksum     <= '0;
            cksum_idx <= 1'b0;
        end else begin
            if (tx_fifo_data_write && (state == HDR || state == BYTES))
                cksum <= cksum + {8'h00, tx_fifo_data};
            if (state == CKSUM && tx_fifo_data_write)
                cksum_idx <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_udp_acq_tx_packer.sv
// Scoreboard bench for udp_acq_tx_packer: stimulus pushes expected bytes/status, a monitor pops and compares.
module tb_udp_acq_tx_packer;

    localparam int WPP = 64;
    localparam int TO  = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [47:0]  destination_mac;
    logic [31:0]  destination_ip;
    logic [107:0] acq_rddata_fifo_108 = '0;
    logic         acq_rdempty_fifo_108 = 1'b1;
    logic         acq_rdreq_fifo_108;
    logic [7:0]   tx_fifo_data;
    logic         tx_fifo_data_write;
    logic         tx_fifo_data_full = 1'b0;
    logic [95:0]  tx_fifo_status;
    logic         tx_fifo_status_write;
    logic         tx_fifo_status_full = 1'b0;
    logic         busy;
    logic [31:0]  packet_count;

    udp_acq_tx_packer #(.WORDS_PER_PKT(WPP), .TIMEOUT_CYCLES(TO)) dut (
        .clk                  (clk),
        .reset                (reset),
        .enable               (enable),
        .destination_mac      (destination_mac),
        .destination_ip       (destination_ip),
        .acq_rddata_fifo_108  (acq_rddata_fifo_108),
        .acq_rdempty_fifo_108 (acq_rdempty_fifo_108),
        .acq_rdreq_fifo_108   (acq_rdreq_fifo_108),
        .tx_fifo_data         (tx_fifo_data),
        .tx_fifo_data_write   (tx_fifo_data_write),
        .tx_fifo_data_full    (tx_fifo_data_full),
        .tx_fifo_status       (tx_fifo_status),
        .tx_fifo_status_write (tx_fifo_status_write),
        .tx_fifo_status_full  (tx_fifo_status_full),
        .busy                 (busy),
        .packet_count         (packet_count)
    );

    always #5 clk = ~clk;

    logic [7:0]   exp_bytes[$];
    logic [95:0]  exp_status[$];
    logic [107:0] acq_q[$];
    logic [15:0]  got_lens[$];
    int           checks = 0;
    int           errors = 0;
    int           byte_count = 0;
    int           status_count = 0;
    int           pops = 0;
    logic [15:0]  exp_seq = '0;
    logic [15:0]  pkt_sum = '0;
    logic [15:0]  last_len = '0;
    logic [7:0]   mon_byte;
    logic [95:0]  mon_status;
    logic         pend_pop;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [107:0] gen_word(input int k);
        return {12'(k), 32'(32'(k) * 32'h0101_0101 + 32'h0000_1234), 64'hDEAD_BEEF_0000_0000 | 64'(k)};
    endfunction

    task automatic update_acq();
        acq_rddata_fifo_108  = (acq_q.size() > 0) ? acq_q[0] : '0;
        acq_rdempty_fifo_108 = (acq_q.size() == 0);
    endtask

    task automatic push_byte(input logic [7:0] b);
        exp_bytes.push_back(b);
        pkt_sum = pkt_sum + {8'h00, b};
    endtask

    task automatic push_word(input logic [107:0] w, input int nbytes);
        logic [111:0] ext;
        ext = {4'h0, w};
        for (int k = 0; k < nbytes; k++) push_byte(ext[111 - 8*k -: 8]);
    endtask

    task automatic push_header();
        pkt_sum = '0;
        push_byte(exp_seq[15:8]);
        push_byte(exp_seq[7:0]);
    endtask

    task automatic push_trailer(input int nwords);
        logic [15:0] len;
        logic [15:0] s;
        s = pkt_sum;
`ifdef ACQ_TX_CHECKSUM_EN
        push_byte(s[15:8]);
        push_byte(s[7:0]);
        len = 16'(4 + 14 * nwords);
`else
        len = 16'(2 + 14 * nwords);
`endif
        exp_status.push_back({destination_mac, destination_ip, len});
        exp_seq = exp_seq + 16'd1;
    endtask

    task automatic applyStimulus(input int base, input int n);
        for (int s = 0; s < n; s += WPP) begin
            int cnt;
            cnt = (n - s < WPP) ? (n - s) : WPP;
            push_header();
            for (int i = 0; i < cnt; i++) begin
                logic [107:0] w;
                w = gen_word(base + s + i);
                acq_q.push_back(w);
                push_word(w, 14);
            end
            push_trailer(cnt);
        end
        update_acq();
    endtask

    task automatic applyReset();
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        exp_seq = '0;
    endtask

    task automatic wait_status(input int target, input int budget, input string name);
        int c;
        c = 0;
        while (status_count < target && c < budget) begin
            @(posedge clk); #2;
            c++;
        end
        checkOutput({name, "_status_seen"}, 128'(status_count >= target), 128'(1));
    endtask

    task automatic wait_pops(input int target, input int budget, input string name);
        int c;
        c = 0;
        while (pops < target && c < budget) begin
            @(posedge clk); #2;
            c++;
        end
        checkOutput({name, "_pop_seen"}, 128'(pops >= target), 128'(1));
    endtask

    // Acquisition FIFO model: show-ahead head word, popped one step after the request edge.
    always begin
        @(negedge clk);
        pend_pop = acq_rdreq_fifo_108;
        if (pend_pop) checkOutput("pop_nonempty", 128'(acq_rdempty_fifo_108), 128'(0));
        @(posedge clk); #1;
        if (pend_pop && acq_q.size() > 0) begin
            void'(acq_q.pop_front());
            pops++;
            update_acq();
        end
    end

    // Monitor: every accepted byte/status is compared against the scoreboard queues.
    always @(negedge clk) begin
        if (tx_fifo_data_write) begin
            checkOutput("data_write_not_full", 128'(tx_fifo_data_full), 128'(0));
            if (exp_bytes.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_byte: got 0x%0h, expected none", tx_fifo_data);
            end else begin
                mon_byte = exp_bytes.pop_front();
                checkOutput("payload_byte", 128'(tx_fifo_data), 128'(mon_byte));
            end
            byte_count++;
        end
        if (tx_fifo_status_write) begin
            checkOutput("status_write_not_full", 128'(tx_fifo_status_full), 128'(0));
            if (exp_status.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_status: got 0x%0h, expected none", tx_fifo_status);
            end else begin
                mon_status = exp_status.pop_front();
                checkOutput("status_word", 128'(tx_fifo_status), 128'(mon_status));
            end
            last_len = tx_fifo_status[15:0];
            got_lens.push_back(tx_fifo_status[15:0]);
            status_count++;
        end
    end

    initial begin
        #500000;
        $display("[TB] watchdog expired at %0t", $time);
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin
        int sbase;
        int pbase;
        int bbase;
        int c;
        logic [15:0] cklen;

        destination_mac = 48'h02_00_00_AA_BB_CC;
        destination_ip  = 32'hC0A8_0A01;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_packet_count", 128'(packet_count), 128'(0));
        checkOutput("rst_data_write", 128'(tx_fifo_data_write), 128'(0));
        checkOutput("rst_status_write", 128'(tx_fifo_status_write), 128'(0));
        checkOutput("rst_rdreq", 128'(acq_rdreq_fifo_108), 128'(0));
        checkOutput("rst_data", 128'(tx_fifo_data), 128'(0));
        checkOutput("rst_status", 128'(tx_fifo_status), 128'(0));

        // Three words, no backpressure, timeout flush; MAC changed after start must not leak in
        @(posedge clk); #2;
        applyStimulus(0, 3);
        enable = 1'b1;
        wait_pops(1, 50, "t1");
        destination_mac = 48'h0A_0B_0C_0D_0E_0F;
        wait_status(1, 400, "t1");
`ifdef ACQ_TX_CHECKSUM_EN
        checkOutput("t1_len", 128'(last_len), 128'(16'h002E));
`else
        checkOutput("t1_len", 128'(last_len), 128'(16'h002C));
`endif
        checkOutput("t1_pops", 128'(pops), 128'(3));
        checkOutput("t1_packet_count", 128'(packet_count), 128'(1));
        checkOutput("t1_bytes_drained", 128'(exp_bytes.size()), 128'(0));
        destination_mac = 48'h02_00_00_AA_BB_CC;

        // 130 words split into 64 + 64 + 2
        applyReset();
        sbase = status_count;
        got_lens.delete();
        applyStimulus(100, 130);
        wait_status(sbase + 3, 6000, "t2");
        checkOutput("t2_num_status", 128'(got_lens.size()), 128'(3));
`ifdef ACQ_TX_CHECKSUM_EN
        cklen = 16'd2;
`else
        cklen = 16'd0;
`endif
        if (got_lens.size() == 3) begin
            checkOutput("t2_len0", 128'(got_lens[0]), 128'(16'd898 + cklen));
            checkOutput("t2_len1", 128'(got_lens[1]), 128'(16'd898 + cklen));
            checkOutput("t2_len2", 128'(got_lens[2]), 128'(16'd30 + cklen));
        end
        checkOutput("t2_packet_count", 128'(packet_count), 128'(3));
        checkOutput("t2_pops", 128'(pops), 128'(133));

        // Same three words as the first packet under data and status backpressure
        applyReset();
        sbase = status_count;
        tx_fifo_status_full = 1'b1;
        applyStimulus(0, 3);
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    @(posedge clk); #2;
                    tx_fifo_data_full = i[0];
                end
                tx_fifo_data_full = 1'b0;
            end
            begin
                repeat (150) @(posedge clk);
                #2;
                checkOutput("t3_status_held", 128'(status_count - sbase), 128'(0));
                checkOutput("t3_busy_waiting", 128'(busy), 128'(1));
                tx_fifo_status_full = 1'b0;
            end
        join
        wait_status(sbase + 1, 50, "t3");
        repeat (5) @(posedge clk);
        #2;
        checkOutput("t3_status_once", 128'(status_count - sbase), 128'(1));
        checkOutput("t3_bytes_drained", 128'(exp_bytes.size()), 128'(0));
        checkOutput("t3_packet_count", 128'(packet_count), 128'(1));

        // Reset in the middle of byte 7 of word 2 abandons the packet
        sbase = status_count;
        pbase = pops;
        bbase = byte_count;
        push_header();
        push_word(gen_word(500), 14);
        push_word(gen_word(501), 7);
        acq_q.push_back(gen_word(500));
        acq_q.push_back(gen_word(501));
        update_acq();
        c = 0;
        while (byte_count < bbase + 23 && c < 200) begin
            @(posedge clk); #2;
            c++;
        end
        checkOutput("t5_reached_byte7", 128'(byte_count - bbase), 128'(23));
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        checkOutput("t5_write_masked", 128'(tx_fifo_data_write), 128'(0));
        @(posedge clk); #2;
        reset   = 1'b0;
        exp_seq = '0;
        @(negedge clk);
        checkOutput("t5_busy", 128'(busy), 128'(0));
        checkOutput("t5_packet_count", 128'(packet_count), 128'(0));
        checkOutput("t5_data", 128'(tx_fifo_data), 128'(0));
        checkOutput("t5_status", 128'(tx_fifo_status), 128'(0));
        checkOutput("t5_no_status", 128'(status_count - sbase), 128'(0));
        checkOutput("t5_bytes_drained", 128'(exp_bytes.size()), 128'(0));
        checkOutput("t5_pops", 128'(pops - pbase), 128'(2));

        // One word, enable dropped during BYTES: short packet with seq 0, no timeout wait
        @(posedge clk); #2;
        sbase = status_count;
        pbase = pops;
        applyStimulus(600, 1);
        enable = 1'b1;
        wait_pops(pbase + 1, 50, "t4");
        enable = 1'b0;
        c = 0;
        while (status_count == sbase && c < 100) begin
            @(posedge clk); #2;
            c++;
        end
        checkOutput("t4_quick_flush", 128'(c <= 20), 128'(1));
`ifdef ACQ_TX_CHECKSUM_EN
        checkOutput("t4_len", 128'(last_len), 128'(16'd18));
`else
        checkOutput("t4_len", 128'(last_len), 128'(16'd16));
`endif
        checkOutput("t4_packet_count", 128'(packet_count), 128'(1));

        // Hand-computed word 0x0102 packet with seq 0
        applyReset();
        sbase = status_count;
        for (int i = 0; i < 14; i++) exp_bytes.push_back(8'h00);
        exp_bytes.push_back(8'h01);
        exp_bytes.push_back(8'h02);
`ifdef ACQ_TX_CHECKSUM_EN
        exp_bytes.push_back(8'h00);
        exp_bytes.push_back(8'h03);
        exp_status.push_back({destination_mac, destination_ip, 16'h0012});
`else
        exp_status.push_back({destination_mac, destination_ip, 16'h0010});
`endif
        acq_q.push_back(108'h0102);
        update_acq();
        enable = 1'b1;
        wait_status(sbase + 1, 200, "t7");
        checkOutput("t7_bytes_drained", 128'(exp_bytes.size()), 128'(0));
        checkOutput("t7_status_drained", 128'(exp_status.size()), 128'(0));
        checkOutput("t7_packet_count", 128'(packet_count), 128'(1));

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
